// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the instruction-fetch controller: next-PC sources, FSM states, default code base.
// No logic of its own; purely declarations and one helper.
// Imported by every fetch_ctrl file.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_RUN   = 2'b01,
    S_HALT  = 2'b10,
    S_FAULT = 2'b11
  } state_e;

  localparam logic [31:0] PC_BASE_DEFAULT = 32'h0000_3000;

  // Branch displacement: word offset sign-extended and turned into a byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_npc.sv
// Next-PC selection and legality check against the code window.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether npc is taken.
module fetch_ctrl_npc
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_BASE = PC_BASE_DEFAULT,
  parameter int          IM_AW   = 10
) (
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] jr_target,
  output logic [31:0] npc,
  output logic        npc_illegal
);

  // Window size in bytes; 33 bits so a full-width window cannot overflow.
  localparam logic [32:0] WIN_BYTES = 33'd4 << IM_AW;

  logic [31:0] pc_plus4;
  logic [31:0] win_off;

  assign pc_plus4 = pc + 32'd4;

  // Pick the next PC from the requested source.
  always_comb begin
    npc = pc_plus4;
    case (npc_sel_e'(npc_sel))
      NPC_SEQ: npc = pc_plus4;
      NPC_BR:  npc = br_taken ? (pc_plus4 + br_offset(imm16)) : pc_plus4;
      NPC_J:   npc = {pc_plus4[31:28], imm26, 2'b00};
      NPC_JR:  npc = jr_target;
      default: npc = pc_plus4;
    endcase
  end

  // Offset from base wraps to a huge value when npc is below the window,
  // so a single unsigned compare covers both window edges.
  assign win_off     = npc - PC_BASE;
  assign npc_illegal = (npc[1:0] != 2'b00) || ({1'b0, win_off} >= WIN_BYTES);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC register, boot/run/halt/fault FSM, retired-instruction counter.
// Latency: instr is combinational from the current PC; control inputs reach the PC after 1 edge.
// Backpressure: stall holds the PC; halt and fault stop fetching until reset.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_BASE = PC_BASE_DEFAULT,
  parameter int          IM_AW   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       npc_sel,
  input  logic             br_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  input  logic [31:0]      jr_target,
  input  logic             halt_req,
  input  logic [31:0]      im_dout,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             halted,
  output logic             fault,
  output logic [31:0]      inst_count
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fv_q, fv_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic [31:0] npc;
  logic        npc_illegal;

  fetch_ctrl_npc #(
    .PC_BASE (PC_BASE),
    .IM_AW   (IM_AW)
  ) u_npc (
    .pc          (pc_q),
    .npc_sel     (npc_sel),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .imm26       (imm26),
    .jr_target   (jr_target),
    .npc         (npc),
    .npc_illegal (npc_illegal)
  );

  // Next-state logic: one action per RUN cycle, halt beats fault beats stall.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (halt_req) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (npc_illegal) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else if (!stall) begin
          pc_d  = npc;
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = state_q;
    endcase
    fv_d = (state_d == S_RUN);
  end

  // FSM, PC and counter registers with synchronous reset back to BOOT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_BOOT;
      pc_q     <= PC_BASE;
      cnt_q    <= 32'd0;
      fv_q     <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      fv_q     <= fv_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign im_addr     = pc_q[IM_AW+1:2];
  assign fetch_valid = fv_q;
  assign instr       = fv_q ? im_dout : 32'd0;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign inst_count  = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
// Instruction memory is a tiny combinational model whose word encodes its own address.
// The run ends with a bounded drain of the scoreboard and one summary line.
module tb_fetch_ctrl;

  localparam int IM_AW = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic [1:0]       npc_sel;
  logic             br_taken;
  logic [15:0]      imm16;
  logic [25:0]      imm26;
  logic [31:0]      jr_target;
  logic             halt_req;
  logic [31:0]      im_dout;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      instr;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             fetch_valid;
  logic             halted;
  logic             fault;
  logic [31:0]      inst_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        fv;
    logic        halted;
    logic        fault;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Memory model: word tagged with a marker and its word address.
  assign im_dout = {16'hA5A5, 6'd0, im_addr};

  fetch_ctrl #(.PC_BASE(32'h0000_3000), .IM_AW(IM_AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .npc_sel     (npc_sel),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .imm26       (imm26),
    .jr_target   (jr_target),
    .halt_req    (halt_req),
    .im_dout     (im_dout),
    .im_addr     (im_addr),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .fault       (fault),
    .inst_count  (inst_count)
  );

  task automatic check(input string name, input string field, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, want %h", name, field, act, expv);
    end
  endtask

  // Monitor: one expectation per cycle, checked on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [31:0] e_instr;
      logic [31:0] e_addr;
      e = sb.pop_front();
      e_addr  = {22'd0, e.pc[11:2]};
      e_instr = e.fv ? {16'hA5A5, 6'd0, e.pc[11:2]} : 32'd0;
      check(e.name, "pc",          pc,                   e.pc);
      check(e.name, "pc_plus4",    pc_plus4,             e.pc + 32'd4);
      check(e.name, "im_addr",     {22'd0, im_addr},     e_addr);
      check(e.name, "instr",       instr,                e_instr);
      check(e.name, "fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
      check(e.name, "halted",      {31'd0, halted},      {31'd0, e.halted});
      check(e.name, "fault",       {31'd0, fault},       {31'd0, e.fault});
      check(e.name, "inst_count",  inst_count,           e.cnt);
    end
  end

  // Apply one cycle of inputs and queue the expected outputs after that edge.
  task automatic cyc(input string name,
                     input logic r, input logic st, input logic [1:0] sel, input logic bt,
                     input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] jr,
                     input logic hr,
                     input logic [31:0] e_pc, input logic e_fv, input logic e_h, input logic e_f,
                     input logic [31:0] e_cnt);
    exp_t e;
    rst = r; stall = st; npc_sel = sel; br_taken = bt;
    imm16 = i16; imm26 = i26; jr_target = jr; halt_req = hr;
    @(posedge clk);
    e.name = name; e.pc = e_pc; e.fv = e_fv; e.halted = e_h; e.fault = e_f; e.cnt = e_cnt;
    sb.push_back(e);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; npc_sel = 2'b00; br_taken = 1'b0;
    imm16 = 16'd0; imm26 = 26'd0; jr_target = 32'd0; halt_req = 1'b0;
    #2;
    //        name        rst st sel   bt imm16     imm26      jr          hr  pc           fv h  f  cnt
    cyc("reset0",   1, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3000, 0, 0, 0, 0);
    cyc("reset1",   1, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3000, 0, 0, 0, 0);
    cyc("boot",     0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3000, 1, 0, 0, 0);
    cyc("seq1",     0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3004, 1, 0, 0, 1);
    cyc("seq2",     0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3008, 1, 0, 0, 2);
    cyc("seq3",     0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h300C, 1, 0, 0, 3);
    cyc("seq4",     0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3010, 1, 0, 0, 4);
    cyc("br_take",  0, 0, 2'b01, 1, 16'hFFFC, 26'h0,     32'h0,      0,  32'h3004, 1, 0, 0, 5);
    cyc("seq5",     0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3008, 1, 0, 0, 6);
    cyc("seq6",     0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h300C, 1, 0, 0, 7);
    cyc("seq7",     0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3010, 1, 0, 0, 8);
    cyc("br_not",   0, 0, 2'b01, 0, 16'hFFFC, 26'h0,     32'h0,      0,  32'h3014, 1, 0, 0, 9);
    cyc("jump",     0, 0, 2'b10, 0, 16'h0,    26'h0C10,  32'h0,      0,  32'h3040, 1, 0, 0, 10);
    cyc("jr_top",   0, 0, 2'b11, 0, 16'h0,    26'h0,     32'h3FFC,   0,  32'h3FFC, 1, 0, 0, 11);
    cyc("win_end",  0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3FFC, 0, 0, 1, 11);
    cyc("flt_hold", 0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      1,  32'h3FFC, 0, 0, 1, 11);
    cyc("rst_flt",  1, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3000, 0, 0, 0, 0);
    cyc("boot2",    0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3000, 1, 0, 0, 0);
    cyc("seq8",     0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3004, 1, 0, 0, 1);
    cyc("mis_stl",  0, 1, 2'b11, 0, 16'h0,    26'h0,     32'h3002,   0,  32'h3004, 0, 0, 1, 1);
    cyc("rst2",     1, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3000, 0, 0, 0, 0);
    cyc("boot3",    0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3000, 1, 0, 0, 0);
    cyc("seq9",     0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3004, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc("stall",  0, 1, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3004, 1, 0, 0, 1);
    cyc("mis_halt", 0, 0, 2'b11, 0, 16'h0,    26'h0,     32'h3002,   1,  32'h3004, 0, 1, 0, 1);
    cyc("hlt_hold", 0, 0, 2'b11, 0, 16'h0,    26'h0,     32'h3002,   0,  32'h3004, 0, 1, 0, 1);
    cyc("rst_hlt",  1, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3000, 0, 0, 0, 0);
    cyc("boot4",    0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3000, 1, 0, 0, 0);
    cyc("seq10",    0, 0, 2'b00, 0, 16'h0,    26'h0,     32'h0,      0,  32'h3004, 1, 0, 0, 1);
    cyc("below",    0, 0, 2'b11, 0, 16'h0,    26'h0,     32'h2FFC,   0,  32'h3004, 0, 0, 1, 1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
